// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 digest loader.
package md5_pkg;

    localparam int DIGEST_W     = 128;
    localparam int DIGEST_BYTES = DIGEST_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } loader_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_decoder.sv
// Combinational ASCII hex character to nibble decoder ('0'-'9', 'a'-'f', 'A'-'F').
module hex_nibble_decoder (
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    always_comb begin
        nibble_o = '0;
        is_hex_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            nibble_o = 4'(char_i - 8'h30);
            is_hex_o = 1'b1;
        end else if (char_i >= 8'h61 && char_i <= 8'h66) begin
            nibble_o = 4'(char_i - 8'h57);
            is_hex_o = 1'b1;
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            nibble_o = 4'(char_i - 8'h37);
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/digest_loader.sv
// Assembles the target digest from the UART byte stream and commits it atomically.
// Define DIGEST_LOADER_HEX_ASCII_EN to accept ASCII hex characters instead of raw bytes.
module digest_loader
    import md5_pkg::*;
#(
    parameter int DIGEST_W       = md5_pkg::DIGEST_W,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                abort,
    output logic [DIGEST_W-1:0] target,
    output logic                target_valid,
    output logic                load_done,
    output logic                load_err,
    output logic                loading
);

`ifdef DIGEST_LOADER_HEX_ASCII_EN
    localparam int UNIT_W = 4;
`else
    localparam int UNIT_W = 8;
`endif
    localparam int UNITS = DIGEST_W / UNIT_W;
    localparam int CNT_W = $clog2(UNITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNITS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    loader_state_t       state_q, state_d;
    logic [DIGEST_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DIGEST_W-1:0] target_q;
    logic                ready_q;
    logic                valid_q;
    logic                done_q;
    logic                err_q, err_d;

    logic                accept;
    logic [UNIT_W-1:0]   unit;
    logic                is_data;
    logic                is_skip;

    assign accept = rx_valid && ready_q;

`ifdef DIGEST_LOADER_HEX_ASCII_EN
    hex_nibble_decoder u_dec (
        .char_i   (rx_data),
        .nibble_o (unit),
        .is_hex_o (is_data)
    );
    assign is_skip = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
`else
    assign unit    = rx_data;
    assign is_data = 1'b1;
    assign is_skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmr_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_data) begin
                        shift_d = DIGEST_W'(unit);
                        cnt_d   = CNT_W'(1);
                        state_d = LOAD;
                    end else if (!is_skip) begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort beats a simultaneous byte; a byte beats a simultaneous timeout.
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (is_data) begin
                        shift_d = {shift_q[DIGEST_W-UNIT_W-1:0], unit};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_LAST) begin
                            state_d = COMMIT;
                        end
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            target_q <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            ready_q <= (state_d != COMMIT);
            err_q   <= err_d;
            done_q  <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                target_q <= shift_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign rx_ready     = ready_q;
    assign target       = target_q;
    assign target_valid = valid_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign loading      = (state_q == LOAD);

endmodule
